// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/serial_adder.sv
// Handshaked multi-cycle adder: STEP bits per clock, LSB-first, WIDTH/STEP cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int NSTEP = (STEP >= 1) ? WIDTH / STEP : 1;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    if (STEP < 1 || STEP > WIDTH || ((STEP >= 1) ? (WIDTH % STEP) : 1) != 0) begin : g_bad_param
        $fatal(1, "serial_adder: illegal parameters WIDTH=%0d STEP=%0d", WIDTH, STEP);
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cout_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [STEP:0]    slice;
    logic [WIDTH-1:0] sum_next;
    logic             last;
`ifdef SERIAL_ADDER_OVF_EN
    logic             a_msb;
    logic             b_msb;
    logic             ovf_r;
`endif

    // Each new slice enters sum from the MSB end, so after NSTEP steps it is aligned.
    always_comb begin
        slice    = {1'b0, a_sh[STEP-1:0]} + {1'b0, b_sh[STEP-1:0]} + {{STEP{1'b0}}, carry};
        sum_next = (sum_r >> STEP) | (WIDTH'(slice[STEP-1:0]) << (WIDTH - STEP));
        last     = (cnt == CW'(NSTEP - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            sum_r       <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            cout_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb       <= 1'b0;
            b_msb       <= 1'b0;
            ovf_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh       <= bus.a;
                        b_sh       <= bus.b;
                        carry      <= bus.cin;
                        cnt        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= RUN;
`ifdef SERIAL_ADDER_OVF_EN
                        a_msb      <= bus.a[WIDTH-1];
                        b_msb      <= bus.b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    sum_r <= sum_next;
                    carry <= slice[STEP];
                    a_sh  <= a_sh >> STEP;
                    b_sh  <= b_sh >> STEP;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        cout_r      <= slice[STEP];
                        out_valid_r <= 1'b1;
                        state       <= DONE;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_r       <= (a_msb == b_msb) && (sum_next[WIDTH-1] != a_msb);
`endif
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: three instances (STEP=1,4,8) at WIDTH=8.
// Define SERIAL_ADDER_OVF_EN to also check ovf.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       out_ready = 1'b1;
    int         sel = 0;
    int         cyc = 0;
    int         passed = 0;
    int         total = 0;

    logic [2:0] in_ready_w;
    logic [2:0] out_valid_w;
    logic [2:0] cout_w;
    logic [2:0] ovf_w;
    logic [7:0] sum_w [3];

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
        int         acc;
    } exp_t;

    exp_t q [3][$];
    int   nstep_of [3] = '{8, 2, 1};
    logic seen [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int S = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
        serial_adder_if #(.WIDTH(8)) bus ();
        serial_adder #(.WIDTH(8), .STEP(S)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
        assign bus.in_valid   = in_valid && (sel == g);
        assign bus.a          = a;
        assign bus.b          = b;
        assign bus.cin        = cin;
        assign bus.out_ready  = out_ready;
        assign in_ready_w[g]  = bus.in_ready;
        assign out_valid_w[g] = bus.out_valid;
        assign sum_w[g]       = bus.sum;
        assign cout_w[g]      = bus.cout;
`ifdef SERIAL_ADDER_OVF_EN
        assign ovf_w[g]       = bus.ovf;
`else
        assign ovf_w[g]       = 1'b0;
`endif
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic monitor_step();
        exp_t e;
        for (int g = 0; g < 3; g++) begin
            if (!rst_n) begin
                seen[g] = 1'b0;
            end else if (out_valid_w[g] && !seen[g]) begin
                seen[g] = 1'b1;
                if (q[g].size() == 0) begin
                    chk($sformatf("g%0d_unexpected_result", g), 32'd1, 32'd0);
                end else begin
                    e = q[g].pop_front();
                    chk($sformatf("g%0d_sum", g), 32'(sum_w[g]), 32'(e.s));
                    chk($sformatf("g%0d_cout", g), 32'(cout_w[g]), 32'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
                    chk($sformatf("g%0d_ovf", g), 32'(ovf_w[g]), 32'(e.o));
`endif
                    chk($sformatf("g%0d_latency", g), 32'(cyc - e.acc), 32'(nstep_of[g]));
                end
            end else if (!out_valid_w[g]) begin
                seen[g] = 1'b0;
            end
        end
    endtask

    // Present operands, wait for acceptance, record expected result on the accept edge.
    task automatic send(input int g, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input logic [7:0] es, input logic ec, input logic eo);
        int n = 0;
        @(negedge clk);
        sel = g; a = av; b = bv; cin = cv; in_valid = 1'b1;
        while (!in_ready_w[g] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk($sformatf("g%0d_accept_timeout", g), 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        q[g].push_back('{es, ec, eo, cyc});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Run a transaction; with out_ready=1 also check in_ready timing around the result.
    task automatic run(input int g, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input logic [7:0] es, input logic ec, input logic eo);
        int   n = 0;
        logic rdy_seen = 1'b0;
        send(g, av, bv, cv, es, ec, eo);
        while (!out_valid_w[g] && n < 40) begin
            rdy_seen |= in_ready_w[g];
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            chk($sformatf("g%0d_result_timeout", g), 32'd0, 32'd1);
            return;
        end
        rdy_seen |= in_ready_w[g];
        chk($sformatf("g%0d_in_ready_low_in_run", g), 32'(rdy_seen), 32'd0);
        if (out_ready) begin
            @(negedge clk);
            chk($sformatf("g%0d_in_ready_after", g), 32'(in_ready_w[g]), 32'd1);
            chk($sformatf("g%0d_out_valid_after", g), 32'(out_valid_w[g]), 32'd0);
        end
    endtask

    initial begin
        logic bad_stable;
        logic bad_ready;
        logic bad_valid;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("g%0d_rst_in_ready", g), 32'(in_ready_w[g]), 32'd1);
            chk($sformatf("g%0d_rst_out_valid", g), 32'(out_valid_w[g]), 32'd0);
            chk($sformatf("g%0d_rst_sum", g), 32'(sum_w[g]), 32'd0);
            chk($sformatf("g%0d_rst_cout", g), 32'(cout_w[g]), 32'd0);
        end
        rst_n = 1'b1;

        // Directed vectors; first two run back-to-back with out_ready tied high
        run(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run(0, 8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, 1'b1);
        run(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        run(1, 8'hF0, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0);
        run(2, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);
        run(2, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

        // Back-pressure: result must hold while extra operands are ignored
        out_ready = 1'b0;
        run(0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        bad_stable = 1'b0; bad_ready = 1'b0; bad_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sel = 0; a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = (i % 2 == 0);
            if (sum_w[0] !== 8'h10 || cout_w[0] !== 1'b0) bad_stable = 1'b1;
            if (in_ready_w[0] !== 1'b0) bad_ready = 1'b1;
            if (out_valid_w[0] !== 1'b1) bad_valid = 1'b1;
        end
        chk("bp_result_stable", 32'(bad_stable), 32'd0);
        chk("bp_in_ready_low", 32'(bad_ready), 32'd0);
        chk("bp_out_valid_held", 32'(bad_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", 32'(out_valid_w[0]), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready_w[0]), 32'd1);
        bad_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid_w[0] !== 1'b0 || in_ready_w[0] !== 1'b1) bad_valid = 1'b1;
        end
        chk("bp_no_capture", 32'(bad_valid), 32'd0);

        // Asynchronous reset in the middle of RUN aborts the operation
        send(0, 8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid_w[0]), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready_w[0]), 32'd1);
        chk("mid_rst_sum", 32'(sum_w[0]), 32'd0);
        chk("mid_rst_cout", 32'(cout_w[0]), 32'd0);
        q[0].delete();
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(q[0].size() + q[1].size() + q[2].size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
